seven_seg_scan: RTL and testbench

//  Drives the real-time clock's BCD time digits (HH.MM) onto a 4-digit, common-anode, multiplexed 7-segment display.

---
 rtl/seven_seg_scan_if.sv | 20 ++
 rtl/seven_seg_scan.sv | 101 ++++++++++
 tb/tb_seven_seg_scan.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_if.sv
// BCD time digits in, multiplexed 7-segment drive out.
interface seven_seg_scan_if;
    logic [3:0] hr_left;
    logic [3:0] hr_right;
    logic [3:0] min_left;
    logic [3:0] min_right;
    logic [6:0] seg_o;
    logic [3:0] an_o;
    logic       dp_o;

    modport master (
        output hr_left, hr_right, min_left, min_right,
        input  seg_o, an_o, dp_o
    );

    modport slave (
        input  hr_left, hr_right, min_left, min_right,
        output seg_o, an_o, dp_o
    );
endinterface

// File: rtl/seven_seg_scan.sv
// 4-digit common-anode scanner for HH.MM with per-frame snapshot and blinking separator.
// Optional: LEADING_ZERO_BLANK_EN blanks a zero hours-tens digit.
module seven_seg_scan #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned REFRESH_HZ = 1000,
    parameter int unsigned BLINK_HZ   = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    seven_seg_scan_if.slave bus
);
    localparam int unsigned SCAN_DIV   = CLK_HZ / REFRESH_HZ;
    localparam int unsigned HALF_BLINK = CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BW = (HALF_BLINK > 1) ? $clog2(HALF_BLINK) : 1;

    logic [PW-1:0]     presc_q, presc_d;
    logic [BW-1:0]     blink_q, blink_d;
    logic              phase_q, phase_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0][3:0]   shadow_q, shadow_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic              slot_tick;
    logic              blink_tc;
    logic [3:0]        digit;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    // Next-state: prescaler, blink timer, scan slot, snapshot and output decode.
    always_comb begin
        slot_tick = (presc_q == PW'(SCAN_DIV - 1));
        presc_d   = slot_tick ? '0 : presc_q + PW'(1);
        blink_tc  = (blink_q == BW'(HALF_BLINK - 1));
        blink_d   = blink_tc ? '0 : blink_q + BW'(1);
        phase_d   = phase_q ^ blink_tc;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        an_d      = an_q;
        seg_d     = seg_q;
        digit     = 4'd0;
        if (slot_tick) begin
            idx_d = idx_q + 2'd1;
            // Frame boundary: the new frame's first slot already shows the fresh snapshot.
            if (idx_q == 2'd3)
                shadow_d = {bus.hr_left, bus.hr_right, bus.min_left, bus.min_right};
            digit = shadow_d[idx_d];
            an_d  = ~(4'b0001 << idx_d);
            seg_d = decode(digit);
`ifdef LEADING_ZERO_BLANK_EN
            if (idx_d == 2'd3 && digit == 4'd0) begin
                an_d  = 4'b1111;
                seg_d = 7'h7F;
            end
`else
`endif
        end
        dp_d = ~((idx_d == 2'd2) && phase_d);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q  <= '0;
            blink_q  <= '0;
            phase_q  <= 1'b0;
            idx_q    <= 2'd0;
            shadow_q <= '0;
            an_q     <= 4'b1111;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
        end else begin
            presc_q  <= presc_d;
            blink_q  <= blink_d;
            phase_q  <= phase_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign bus.seg_o = seg_q;
    assign bus.an_o  = an_q;
    assign bus.dp_o  = dp_q;
endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomized bench for seven_seg_scan against a cycle-count based reference model.
module tb_seven_seg_scan;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   e;
    logic [3:0] snap [4];

    seven_seg_scan_if ssif();

    seven_seg_scan #(.CLK_HZ(16), .REFRESH_HZ(4), .BLINK_HZ(1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ssif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, e);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (d > 4'd9) return 7'h3F;
        return tbl[d];
    endfunction

    // Expected outputs after e edges since reset: e/4 slot ticks, phase flips every 8 edges.
    task automatic check_outputs();
        int         ticks, idx;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        ticks = e / 4;
        idx   = ticks % 4;
        if (ticks == 0) begin
            exp_an  = 4'b1111;
            exp_seg = 7'h7F;
        end else begin
            exp_an       = 4'b1111;
            exp_an[idx]  = 1'b0;
            exp_seg      = seg_of(snap[idx]);
`ifdef LEADING_ZERO_BLANK_EN
            if (idx == 3 && snap[3] == 4'd0) begin
                exp_an  = 4'b1111;
                exp_seg = 7'h7F;
            end
`else
`endif
        end
        exp_dp = !(idx == 2 && ((e / 8) % 2) == 1);
        check("an",  32'(ssif.an_o),  32'(exp_an));
        check("seg", 32'(ssif.seg_o), 32'(exp_seg));
        check("dp",  32'(ssif.dp_o),  32'(exp_dp));
    endtask

    task automatic step();
        @(posedge clk);
        if (e % 16 == 15) begin
            snap[0] = ssif.min_right;
            snap[1] = ssif.min_left;
            snap[2] = ssif.hr_right;
            snap[3] = ssif.hr_left;
        end
        e++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_digits(input logic [3:0] hl, input logic [3:0] hr,
                              input logic [3:0] ml, input logic [3:0] mr);
        ssif.hr_left   = hl;
        ssif.hr_right  = hr;
        ssif.min_left  = ml;
        ssif.min_right = mr;
    endtask

    // Async reset asserted between edges, released on a falling edge.
    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_an",  32'(ssif.an_o),  32'(4'b1111));
        check("rst_seg", 32'(ssif.seg_o), 32'(7'h7F));
        check("rst_dp",  32'(ssif.dp_o),  32'(1'b1));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        e   = 0;
        for (int i = 0; i < 4; i++) snap[i] = 4'd0;
        check_outputs();
    endtask

    initial begin
        rst = 1'b1;
        e   = 0;
        for (int i = 0; i < 4; i++) snap[i] = 4'd0;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        #12;
        check("por_an", 32'(ssif.an_o), 32'(4'b1111));
        @(negedge clk);
        rst = 1'b0;
        check_outputs();

        // First tick after 4 edges lands on slot 1.
        for (int i = 0; i < 4; i++) step();
        check("first_slot_an", 32'(ssif.an_o), 32'(4'b1101));

        // Steady 12.34 for two frames plus.
        for (int i = 0; i < 40; i++) step();

        // Mid-frame change of min_right.
        for (int i = 0; i < 6; i++) step();
        ssif.min_right = 4'd7;
        for (int i = 0; i < 40; i++) step();

        // Illegal BCD and zero hours-tens.
        set_digits(4'd0, 4'd9, 4'hC, 4'd8);
        for (int i = 0; i < 40; i++) step();

        // Mid-frame reset, then the directed post-reset slot check again.
        for (int i = 0; i < 5; i++) step();
        pulse_reset();
        for (int i = 0; i < 4; i++) step();
        check("post_rst_an", 32'(ssif.an_o), 32'(4'b1101));

        // Randomized digits changing at arbitrary cycles.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0)
                set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0)
                ssif.hr_left = 4'd0;
            step();
            if (i == 217) pulse_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
